// File: rtl/btn_debouncer_pkg.sv
// debounce_pkg: shared state encoding and default parameter values for the
// button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_FALL = 2'd2,
    S_HIGH = 2'd3
  } db_state_e;

  localparam int DEF_STABLE_SAMPLES = 4;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_HOLD_SAMPLES   = 64;

endpackage : debounce_pkg

// File: rtl/btn_debouncer_sync.sv
// btn_sync: SYNC_STAGES-deep flop chain bringing the raw asynchronous button
// into the i_clk domain. Clears asynchronously to 0.
module btn_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("btn_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the chain every clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule : btn_sync

// File: rtl/btn_debouncer.sv
// btn_debouncer: synchronises a raw button, samples it on rising edges of a
// divided clock level (i_sclk) and accepts a new level only after
// STABLE_SAMPLES consecutive equal samples. Produces a registered clean level
// plus one-cycle press/release pulses.
// Optional build macro DEBOUNCE_HOLD_EN: adds a long-press pulse on o_hold
// after HOLD_SAMPLES samples spent in S_HIGH; without it o_hold is tied low.
module btn_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int HOLD_SAMPLES   = DEF_HOLD_SAMPLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_btn,
  output logic o_btn,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  if (STABLE_SAMPLES < 1) begin : g_bad_stable_samples
    $error("btn_debouncer: STABLE_SAMPLES must be >= 1");
  end
  if (HOLD_SAMPLES < 1) begin : g_bad_hold_samples
    $error("btn_debouncer: HOLD_SAMPLES must be >= 1");
  end

  localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            sclk_q;
  logic            sample_en;
  logic            btn_s;
  db_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic            btn_q;
  logic            press_q;
  logic            release_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              hold_pulse_q;

  assign hold_d = hold_q + HOLD_ONE;
`endif

  btn_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn),
    .o_q     (btn_s)
  );

  // Previous i_sclk level; resets high so a high i_sclk at reset release
  // does not look like a rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_q <= 1'b1;
    end else begin
      sclk_q <= i_sclk;
    end
  end

  assign sample_en = i_sclk & ~sclk_q;
  assign cnt_d     = cnt_q + CNT_ONE;

  // Debounce FSM: advances only on sample edges; pulses default low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef DEBOUNCE_HOLD_EN
      hold_q       <= '0;
      hold_pulse_q <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef DEBOUNCE_HOLD_EN
      hold_pulse_q <= 1'b0;
`endif
      if (sample_en) begin
        case (state_q)
          S_LOW: begin
            if (btn_s) begin
              if (STABLE_SAMPLES == 1) begin
                state_q <= S_HIGH;
                cnt_q   <= '0;
                btn_q   <= 1'b1;
                press_q <= 1'b1;
              end else begin
                state_q <= S_RISE;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          S_RISE: begin
            if (!btn_s) begin
              state_q <= S_LOW;
              cnt_q   <= '0;
            end else if (cnt_d == CNT_LAST) begin
              state_q <= S_HIGH;
              cnt_q   <= '0;
              btn_q   <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          S_HIGH: begin
            if (!btn_s) begin
              if (STABLE_SAMPLES == 1) begin
                state_q   <= S_LOW;
                cnt_q     <= '0;
                btn_q     <= 1'b0;
                release_q <= 1'b1;
              end else begin
                state_q <= S_FALL;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          S_FALL: begin
            if (btn_s) begin
              state_q <= S_HIGH;
              cnt_q   <= '0;
            end else if (cnt_d == CNT_LAST) begin
              state_q   <= S_LOW;
              cnt_q     <= '0;
              btn_q     <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end
        endcase
`ifdef DEBOUNCE_HOLD_EN
        // Count samples that keep us in S_HIGH; saturate so the pulse
        // fires once per press. Any other sample clears the count.
        if ((state_q == S_HIGH) && btn_s) begin
          if (hold_q != HOLD_LAST) begin
            hold_q <= hold_d;
            if (hold_d == HOLD_LAST) begin
              hold_pulse_q <= 1'b1;
            end
          end
        end else begin
          hold_q <= '0;
        end
`endif
      end
    end
  end

  assign o_btn     = btn_q;
  assign o_press   = press_q;
  assign o_release = release_q;
`ifdef DEBOUNCE_HOLD_EN
  assign o_hold    = hold_pulse_q;
`else
  assign o_hold    = 1'b0;
`endif

endmodule : btn_debouncer

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with STABLE_SAMPLES=4, SYNC_STAGES=2,
// HOLD_SAMPLES=8 and i_sclk taken from a free-running 2-bit divider.
// A sample edge is the posedge where div==2; the bench steps to the negedge
// right after each sample edge (div==3) and checks there.
module tb_btn_debouncer;

`ifdef DEBOUNCE_HOLD_EN
  localparam int HOLD_EXP = 1;
`else
  localparam int HOLD_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       btn;
  logic       o_btn, o_press, o_release, o_hold;
  logic [1:0] div = 2'd0;

  int total = 0;
  int bad = 0;
  int press_cyc = 0;
  int rel_cyc = 0;
  int hold_cyc = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  always @(posedge clk) div <= div + 2'd1;
  assign sclk = div[1];

  btn_debouncer #(
    .STABLE_SAMPLES (4),
    .SYNC_STAGES    (2),
    .HOLD_SAMPLES   (8)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_sclk    (sclk),
    .i_btn     (btn),
    .o_btn     (o_btn),
    .o_press   (o_press),
    .o_release (o_release),
    .o_hold    (o_hold)
  );

  // Pulse-width bookkeeping, one count per cycle a pulse is seen high.
  always @(negedge clk) begin
    if (o_press === 1'b1) press_cyc++;
    if (o_release === 1'b1) rel_cyc++;
    if (o_hold === 1'b1) hold_cyc++;
    if (o_press === 1'b1 && o_release === 1'b1) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Step to the negedge just after the n-th following sample edge.
  task automatic wait_samples(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (div != 2'd3) @(negedge clk);
    end
  endtask

  task automatic go_low();
    wait_samples(1);
    btn = 1'b0;
    wait_samples(6);
  endtask

  task automatic test_reset();
    int p0;
    btn   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (o_btn !== 1'b0) begin bad++; $display("FAIL rst_btn: got %b want 0", o_btn); end
    total++; if (o_press !== 1'b0) begin bad++; $display("FAIL rst_press: got %b want 0", o_press); end
    total++; if (o_release !== 1'b0) begin bad++; $display("FAIL rst_release: got %b want 0", o_release); end
    total++; if (o_hold !== 1'b0) begin bad++; $display("FAIL rst_hold: got %b want 0", o_hold); end
    @(negedge clk);
    while (div != 2'd3) @(negedge clk);
    rst_n = 1'b1;
    p0 = press_cyc;
    @(negedge clk);
    total++; if (o_press !== 1'b0) begin bad++; $display("FAIL rst_first_cycle: got %b want 0", o_press); end
    wait_samples(3);
    total++; if (press_cyc != p0) begin bad++; $display("FAIL rst_early_press: got %0d want %0d", press_cyc, p0); end
    wait_samples(1);
    total++; if (o_press !== 1'b1) begin bad++; $display("FAIL rst_press_4th: got %b want 1", o_press); end
    total++; if (o_btn !== 1'b1) begin bad++; $display("FAIL rst_btn_4th: got %b want 1", o_btn); end
    @(negedge clk);
    total++; if (press_cyc != p0 + 1) begin bad++; $display("FAIL rst_press_width: got %0d want %0d", press_cyc - p0, 1); end
  endtask

  task automatic test_glitch_release();
    int r0;
    wait_samples(1);
    r0 = rel_cyc;
    @(negedge clk); @(negedge clk);
    btn = 1'b0;
    @(negedge clk); @(negedge clk);
    btn = 1'b1;
    wait_samples(3);
    total++; if (o_btn !== 1'b1) begin bad++; $display("FAIL glitch_btn: got %b want 1", o_btn); end
    total++; if (rel_cyc != r0) begin bad++; $display("FAIL glitch_release: got %0d want %0d", rel_cyc, r0); end
    btn = 1'b0;
    wait_samples(1);
    btn = 1'b1;
    wait_samples(4);
    total++; if (o_btn !== 1'b1) begin bad++; $display("FAIL bounce_fall_btn: got %b want 1", o_btn); end
    total++; if (rel_cyc != r0) begin bad++; $display("FAIL bounce_fall_release: got %0d want %0d", rel_cyc, r0); end
    btn = 1'b0;
    wait_samples(3);
    total++; if (o_btn !== 1'b1) begin bad++; $display("FAIL release_early_btn: got %b want 1", o_btn); end
    total++; if (rel_cyc != r0) begin bad++; $display("FAIL release_early: got %0d want %0d", rel_cyc, r0); end
    wait_samples(1);
    total++; if (o_release !== 1'b1) begin bad++; $display("FAIL release_pulse: got %b want 1", o_release); end
    total++; if (o_btn !== 1'b0) begin bad++; $display("FAIL release_btn: got %b want 0", o_btn); end
    @(negedge clk);
    total++; if (o_release !== 1'b0) begin bad++; $display("FAIL release_after: got %b want 0", o_release); end
    total++; if (rel_cyc != r0 + 1) begin bad++; $display("FAIL release_width: got %0d want %0d", rel_cyc - r0, 1); end
  endtask

  task automatic test_bounce();
    int p0;
    wait_samples(1);
    p0 = press_cyc;
    btn = 1'b1;
    wait_samples(3);
    total++; if (press_cyc != p0) begin bad++; $display("FAIL bounce_3of4: got %0d want %0d", press_cyc, p0); end
    btn = 1'b0;
    wait_samples(1);
    total++; if (o_btn !== 1'b0) begin bad++; $display("FAIL bounce_btn: got %b want 0", o_btn); end
    total++; if (press_cyc != p0) begin bad++; $display("FAIL bounce_4th_low: got %0d want %0d", press_cyc, p0); end
    btn = 1'b1;
    wait_samples(3);
    total++; if (press_cyc != p0) begin bad++; $display("FAIL bounce_early: got %0d want %0d", press_cyc, p0); end
    wait_samples(1);
    total++; if (o_press !== 1'b1) begin bad++; $display("FAIL bounce_press: got %b want 1", o_press); end
    total++; if (o_btn !== 1'b1) begin bad++; $display("FAIL bounce_press_btn: got %b want 1", o_btn); end
  endtask

  task automatic test_clean_press();
    int p0, r0;
    go_low();
    p0 = press_cyc;
    r0 = rel_cyc;
    btn = 1'b1;
    wait_samples(3);
    total++; if (press_cyc != p0) begin bad++; $display("FAIL press_early: got %0d want %0d", press_cyc, p0); end
    total++; if (o_btn !== 1'b0) begin bad++; $display("FAIL press_early_btn: got %b want 0", o_btn); end
    wait_samples(1);
    total++; if (o_press !== 1'b1) begin bad++; $display("FAIL press_pulse: got %b want 1", o_press); end
    total++; if (o_btn !== 1'b1) begin bad++; $display("FAIL press_btn: got %b want 1", o_btn); end
    total++; if (o_release !== 1'b0) begin bad++; $display("FAIL press_release: got %b want 0", o_release); end
    @(negedge clk);
    total++; if (o_press !== 1'b0) begin bad++; $display("FAIL press_after: got %b want 0", o_press); end
    total++; if (o_btn !== 1'b1) begin bad++; $display("FAIL press_after_btn: got %b want 1", o_btn); end
    total++; if (press_cyc != p0 + 1) begin bad++; $display("FAIL press_width: got %0d want %0d", press_cyc - p0, 1); end
    total++; if (rel_cyc != r0) begin bad++; $display("FAIL press_no_release: got %0d want %0d", rel_cyc, r0); end
  endtask

  task automatic test_reset_mid();
    int p0;
    go_low();
    btn = 1'b1;
    wait_samples(2);
    rst_n = 1'b0;
    #1;
    total++; if (o_btn !== 1'b0) begin bad++; $display("FAIL mid_rst_btn: got %b want 0", o_btn); end
    p0 = press_cyc;
    wait_samples(1);
    rst_n = 1'b1;
    wait_samples(3);
    total++; if (press_cyc != p0) begin bad++; $display("FAIL mid_rst_early: got %0d want %0d", press_cyc, p0); end
    total++; if (o_btn !== 1'b0) begin bad++; $display("FAIL mid_rst_early_btn: got %b want 0", o_btn); end
    wait_samples(1);
    total++; if (o_press !== 1'b1) begin bad++; $display("FAIL mid_rst_press: got %b want 1", o_press); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (o_btn !== 1'b0) begin bad++; $display("FAIL async_rst_btn: got %b want 0", o_btn); end
    btn = 1'b0;
    wait_samples(1);
    rst_n = 1'b1;
  endtask

  task automatic test_hold();
    int h0;
    go_low();
    h0 = hold_cyc;
    btn = 1'b1;
    wait_samples(4);
    total++; if (o_press !== 1'b1) begin bad++; $display("FAIL hold_press: got %b want 1", o_press); end
    wait_samples(7);
    total++; if (hold_cyc != h0) begin bad++; $display("FAIL hold_early: got %0d want %0d", hold_cyc, h0); end
    wait_samples(1);
    total++; if (o_hold !== 1'(HOLD_EXP)) begin bad++; $display("FAIL hold_pulse: got %b want %0d", o_hold, HOLD_EXP); end
    @(negedge clk);
    total++; if (o_hold !== 1'b0) begin bad++; $display("FAIL hold_after: got %b want 0", o_hold); end
    wait_samples(12);
    total++; if (hold_cyc != h0 + HOLD_EXP) begin bad++; $display("FAIL hold_once: got %0d want %0d", hold_cyc - h0, HOLD_EXP); end
    total++; if (o_btn !== 1'b1) begin bad++; $display("FAIL hold_btn: got %b want 1", o_btn); end
  endtask

  task automatic test_no_overlap();
    total++; if (overlap != 0) begin bad++; $display("FAIL press_release_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    btn   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_glitch_release();
    test_bounce();
    test_clean_press();
    test_reset_mid();
    test_hold();
    test_no_overlap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_btn_debouncer
